boot_sequencer: RTL and testbench

- Sequences the single-cycle RV32I core through load, run and halt.
- Holds the core in reset while it streams a program, byte by byte, into instruction memory. It then releases the core and counts executed cycles until the core signals halt.
- Sits between `top` and the instruction memory write port. The core itself is unchanged.

---
 rtl/boot_pkg.sv | 15 +
 rtl/boot_sequencer_byte_packer.sv | 34 +++
 rtl/boot_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_boot_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state type, word geometry and default widths for the boot sequencer
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } boot_state_t;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 32;

endpackage

// File: rtl/boot_sequencer_byte_packer.sv
// rtl/boot_sequencer_byte_packer.sv - assembles little-endian bytes into 32-bit words
// word_valid is combinational with the 4th byte so the sequencer can register the write.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      low <= 24'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (byte_valid) begin
      // shift right so byte 0 ends up in the least significant lane
      low <= {byte_data, low[23:8]};
      idx <= idx + 2'd1;
    end
  end

  assign word_valid = byte_valid && (idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, low};

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a program into imem while holding the core in reset, then runs it to halt
// Optional trailing checksum byte on the program stream: BOOT_SEQ_CHECKSUM_EN.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  halt,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  core_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  boot_state_t           state, state_n;
  logic [ADDR_WIDTH:0]   widx, widx_n;
  logic [ADDR_WIDTH:0]   len_q, len_n;
  logic [ADDR_WIDTH:0]   len_last;
  logic                  rx_ready_n, imem_we_n, core_rst_n, core_en_n;
  logic                  busy_n, done_n, err_n;
  logic [ADDR_WIDTH-1:0] imem_addr_n;
  logic [31:0]           imem_wdata_n;
  logic [CNT_WIDTH-1:0]  cnt_n;
  logic                  accept, pk_valid, pk_clear, len_bad;
  logic                  word_valid;
  logic [31:0]           word;

  assign accept   = rx_valid && rx_ready;
  assign len_last = len_q - (ADDR_WIDTH+1)'(1);
  assign len_bad  = (len_words == '0) || (len_words > CAPACITY);

`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [7:0] sum, sum_n;
  // once every word is in, the next accepted byte is the checksum, not program data
  assign pk_valid = accept && (widx != len_q);
`else
  assign pk_valid = accept;
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      widx        <= '0;
      len_q       <= '0;
      rx_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst    <= 1'b1;
      core_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
`ifdef BOOT_SEQ_CHECKSUM_EN
      sum         <= 8'd0;
`endif
    end else begin
      state       <= state_n;
      widx        <= widx_n;
      len_q       <= len_n;
      rx_ready    <= rx_ready_n;
      imem_we     <= imem_we_n;
      imem_addr   <= imem_addr_n;
      imem_wdata  <= imem_wdata_n;
      core_rst    <= core_rst_n;
      core_en     <= core_en_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      cycle_count <= cnt_n;
`ifdef BOOT_SEQ_CHECKSUM_EN
      sum         <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    widx_n       = widx;
    len_n        = len_q;
    rx_ready_n   = rx_ready;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    core_rst_n   = core_rst;
    core_en_n    = core_en;
    busy_n       = busy;
    done_n       = done;
    err_n        = err;
    cnt_n        = cycle_count;
    pk_clear     = 1'b0;
`ifdef BOOT_SEQ_CHECKSUM_EN
    sum_n        = sum;
`endif
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          if (len_bad) begin
            err_n = 1'b1;
          end else begin
            state_n    = LOAD;
            len_n      = len_words;
            widx_n     = '0;
            cnt_n      = '0;
            pk_clear   = 1'b1;
            rx_ready_n = 1'b1;
            core_rst_n = 1'b1;
            core_en_n  = 1'b0;
            busy_n     = 1'b1;
            done_n     = 1'b0;
            err_n      = 1'b0;
`ifdef BOOT_SEQ_CHECKSUM_EN
            sum_n      = 8'd0;
`endif
          end
        end
      end
      LOAD: begin
`ifdef BOOT_SEQ_CHECKSUM_EN
        if (accept && (widx == len_q)) begin
          rx_ready_n = 1'b0;
          if (rx_data == sum) begin
            state_n    = RUN;
            core_rst_n = 1'b0;
            core_en_n  = 1'b1;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
          end
        end else if (accept) begin
          sum_n = sum + rx_data;
        end
`else
        // release the core one cycle after the final word's write strobe
        if (imem_we && ({1'b0, imem_addr} == len_last)) begin
          state_n    = RUN;
          core_rst_n = 1'b0;
          core_en_n  = 1'b1;
        end
`endif
        if (word_valid) begin
          imem_we_n    = 1'b1;
          imem_addr_n  = widx[ADDR_WIDTH-1:0];
          imem_wdata_n = word;
          widx_n       = widx + (ADDR_WIDTH+1)'(1);
`ifndef BOOT_SEQ_CHECKSUM_EN
          if (widx == len_last) rx_ready_n = 1'b0;
`endif
        end
      end
      RUN: begin
        if (cycle_count == '1) err_n = 1'b1;
        else                   cnt_n = cycle_count + 1'b1;
        if (halt) begin
          state_n   = HALTED;
          core_en_n = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - scoreboard bench for boot_sequencer load, run, halt, error and abort paths
module tb_boot_sequencer;

  localparam int AW = 8;
  localparam int CW = 32;

  logic          clk, rst, start, rx_valid, halt;
  logic [AW:0]   len_words;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we, core_rst, core_en, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [CW-1:0] cycle_count;

  int errors = 0;
  int checks = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    prog [0:3];

  boot_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .halt(halt),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
    .err(err), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary, required completion");
    $fatal(1, "watchdog expired");
  end

  // negedge monitor: every write strobe must match the oldest expected write
  task automatic tick();
    logic [AW+31:0] e;
    @(negedge clk);
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic step();
    tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    do begin
      rdy = rx_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    rx_valid = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL rx_handshake: byte %h not accepted in 50 cycles, required acceptance", b);
    end
  endtask

  task automatic start_load(input int len);
    len_words = len[AW:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_prog(input int nbytes, input int gap);
    logic [31:0] w;
    for (int i = 0; i < nbytes; i++) begin
      w = prog[i/4];
      if (i % 4 == 3) exp_q.push_back({8'(i/4), w});
      send_byte(w[8*(i%4) +: 8]);
      if (i < nbytes - 1) repeat (gap) step();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({rx_ready, imem_we, core_rst, core_en, busy, done, err} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/we/crst/cen/busy/done/err=%b, required 0010000",
               {rx_ready, imem_we, core_rst, core_en, busy, done, err});
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== '0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d data=%h cnt=%0d, required 0/0/0", imem_addr, imem_wdata, cycle_count);
    end
    rst = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rx_ready !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_ack: got rdy=%b crst=%b busy=%b, required 0/1/0", rx_ready, core_rst, busy);
      end
    end
    rx_valid = 1'b0;
    halt = 1'b0;
  endtask

  task automatic test_load_two();
    prog[0] = 32'h00500013;
    prog[1] = 32'h00100093;
    start_load(2);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL load_entry: got rdy=%b busy=%b crst=%b, required 1/1/1", rx_ready, busy, core_rst);
    end
    send_prog(8, 0);
    checks++;
`ifdef BOOT_SEQ_CHECKSUM_EN
    if (imem_we !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL last_write_cycle: got we=%b crst=%b, required 1/1", imem_we, core_rst);
    end
    send_byte(8'h06);
`else
    if (imem_we !== 1'b1 || rx_ready !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL last_write_cycle: got we=%b rdy=%b crst=%b, required 1/0/1", imem_we, rx_ready, core_rst);
    end
    step();
`endif
    checks++;
    if (core_rst !== 1'b0 || core_en !== 1'b1 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL core_release: got crst=%b cen=%b we=%b, required 0/1/0", core_rst, core_en, imem_we);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_two_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_run_halt();
    int n;
    n = 0;
    while (core_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL run_wait: got cen=%b after 20 cycles, required 1", core_en);
    end
    start = 1'b1;
    len_words = 9'd1;
    repeat (9) step();
    start = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if (cycle_count !== 32'd10 || done !== 1'b1 || core_en !== 1'b0 || core_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_state: got cnt=%0d done=%b cen=%b crst=%b busy=%b, required 10/1/0/0/0",
               cycle_count, done, core_en, core_rst, busy);
    end
    repeat (4) step();
    checks++;
    if (cycle_count !== 32'd10 || done !== 1'b1) begin
      errors++;
      $display("FAIL halt_frozen: got cnt=%0d done=%b, required 10/1", cycle_count, done);
    end
  endtask

  task automatic test_back_to_back();
    prog[0] = 32'h00000013;
    start_load(1);
    checks++;
    if (core_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || cycle_count !== '0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: got crst=%b done=%b busy=%b cnt=%0d rdy=%b, required 1/0/1/0/1",
               core_rst, done, busy, cycle_count, rx_ready);
    end
    send_prog(4, 1);
`ifdef BOOT_SEQ_CHECKSUM_EN
    send_byte(8'h13);
`else
    step();
`endif
    repeat (3) step();
    checks++;
    if (core_en !== 1'b1 || cycle_count !== 32'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_run: got cen=%b cnt=%0d pending=%0d, required 1/3/0", core_en, cycle_count, exp_q.size());
    end
  endtask

  task automatic test_bad_length();
    pulse_reset();
    start_load(0);
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL len_zero: got err=%b busy=%b rdy=%b crst=%b, required 1/0/0/1", err, busy, rx_ready, core_rst);
    end
    start_load(257);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL len_over: got err=%b busy=%b done=%b, required 1/0/0", err, busy, done);
    end
    start_load(256);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL len_max: got err=%b busy=%b rdy=%b, required 0/1/1", err, busy, rx_ready);
    end
    pulse_reset();
  endtask

  task automatic test_stall_abort();
    prog[0] = 32'h00500013;
    prog[1] = 32'h00100093;
    pulse_reset();
    start_load(2);
    send_prog(8, 3);
`ifdef BOOT_SEQ_CHECKSUM_EN
    send_byte(8'h06);
`else
    step();
`endif
    checks++;
    if (core_en !== 1'b1 || core_rst !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_load: got cen=%b crst=%b pending=%0d, required 1/0/0", core_en, core_rst, exp_q.size());
    end
    pulse_reset();
    start_load(2);
    send_prog(5, 3);
    rst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, imem_we, core_rst, core_en, busy, done, err} !== 7'b0010000 ||
        imem_addr !== '0 || imem_wdata !== '0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL abort_reset: got flags=%b addr=%0d data=%h cnt=%0d, required 0010000/0/0/0",
               {rx_ready, imem_we, core_rst, core_en, busy, done, err}, imem_addr, imem_wdata, cycle_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_first_word: got %0d writes outstanding, required 0", exp_q.size());
    end
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef BOOT_SEQ_CHECKSUM_EN
  task automatic test_checksum();
    prog[0] = 32'h00000013;
    pulse_reset();
    start_load(1);
    send_prog(4, 0);
    send_byte(8'h13);
    checks++;
    if (core_en !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL csum_good: got cen=%b crst=%b err=%b, required 1/0/0", core_en, core_rst, err);
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    start_load(1);
    send_prog(4, 0);
    send_byte(8'h14);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1 || rx_ready !== 1'b0 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad: got err=%b busy=%b crst=%b rdy=%b cen=%b, required 1/0/1/0/0",
               err, busy, core_rst, rx_ready, core_en);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL csum_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len_words = '0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    halt = 1'b0;
    test_reset();
    test_load_two();
    test_run_halt();
    test_back_to_back();
    test_bad_length();
    test_stall_abort();
`ifdef BOOT_SEQ_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
